// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: merges icache/dcache AXI3 read streams onto one AR/R channel, one burst in flight
module axi_read_arbiter #(
    parameter logic [3:0] I_ID    = 4'd0,
    parameter logic [3:0] D_ID    = 4'd1,
    parameter logic [7:0] MAX_LEN = 8'd15
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t      state_q, state_d;
    logic        owner_q, owner_d, last_q, last_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d, cnt_q, cnt_d, sel_len;
    logic [2:0]  arsize_q, arsize_d;
    logic        err_q, err_d;
    logic        pick_d, in_data, beat;
    assign pick_d  = d_arvalid && (!i_arvalid || !last_q);
    assign sel_len = pick_d ? d_arlen : i_arlen;
    assign in_data = state_q == DATA;
    assign rready  = in_data && (owner_q ? d_rready : i_rready);
    assign beat    = in_data && rvalid && rready;
    // Next state: grant in IDLE, wait for arready in ADDR, count and check beats in DATA
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (i_arvalid || d_arvalid) begin
                state_d  = ADDR;
                owner_d  = pick_d;
                last_d   = pick_d;
                arid_d   = pick_d ? D_ID : I_ID;
                araddr_d = pick_d ? d_araddr : i_araddr;
                arlen_d  = sel_len;
                arsize_d = pick_d ? d_arsize : i_arsize;
                err_d    = err_q || (sel_len > MAX_LEN);
            end
            ADDR: if (arready) begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: if (beat) begin
                cnt_d   = cnt_q + 8'd1;
                state_d = rlast ? IDLE : DATA;
                err_d   = err_q || (rlast != (cnt_q == arlen_q)) ||
                          (rid != (owner_q ? D_ID : I_ID)) || (rresp != 2'b00);
            end
            default: state_d = IDLE;
        endcase
    end
    // State and AR payload registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            arid_q   <= arid_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            arsize_q <= arsize_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end
    // Grant pulses are masked by reset so nothing is accepted while held in reset
    assign i_arready = aresetn && state_q == IDLE && i_arvalid && !pick_d;
    assign d_arready = aresetn && state_q == IDLE && pick_d;
    assign arvalid   = state_q == ADDR;
    assign arid      = arid_q;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arsize    = arsize_q;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign i_rvalid  = in_data && !owner_q && rvalid;
    assign i_rdata   = (in_data && !owner_q) ? rdata : '0;
    assign i_rlast   = in_data && !owner_q && rlast;
    assign d_rvalid  = in_data && owner_q && rvalid;
    assign d_rdata   = (in_data && owner_q) ? rdata : '0;
    assign d_rlast   = in_data && owner_q && rlast;
    assign rd_err    = err_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed scenario tests for the icache/dcache read arbiter
module tb_axi_read_arbiter;
    logic aclk = 1'b0, aresetn = 1'b0;
    logic [31:0] i_araddr = '0, d_araddr = '0, i_rdata, d_rdata, araddr, rdata = '0;
    logic [7:0]  i_arlen = '0, d_arlen = '0, arlen;
    logic [2:0]  i_arsize = '0, d_arsize = '0, arsize, arprot;
    logic        i_arvalid = 0, d_arvalid = 0, i_arready, d_arready;
    logic        i_rlast, i_rvalid, d_rlast, d_rvalid, i_rready = 1, d_rready = 1;
    logic [3:0]  arid, arcache, rid = '0;
    logic [1:0]  arburst, arlock, rresp = '0;
    logic        arvalid, arready = 0, rlast = 0, rvalid = 0, rready, rd_err;
    int n_chk = 0, n_fail = 0;

    axi_read_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
        .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        aresetn = 0; i_arvalid = 0; d_arvalid = 0; rvalid = 0; rlast = 0; rresp = 0; arready = 0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1;
        #1;
    endtask

    // Slave model: accepts AR after ar_dly cycles, returns nbeats beats, reports what it saw
    task automatic serve(input int ar_dly, input int nbeats, input logic [3:0] rid_v,
                         input int bad_beat, input int bp_lo, input int bp_hi,
                         output logic [3:0] o_id, output logic [31:0] o_addr,
                         output logic [7:0] o_len, output int o_got, output int o_bad);
        logic own_d, rl;
        logic [31:0] exp;
        int k;
        o_got = 0; o_bad = 0; o_id = '0; o_addr = '0; o_len = '0; k = 0;
        while (arvalid !== 1'b1 && k < 20) begin @(posedge aclk); #1; k++; end
        if (arvalid !== 1'b1) begin o_bad = 1000; return; end
        o_id = arid; o_addr = araddr; o_len = arlen; own_d = (arid == 4'd1);
        repeat (ar_dly) begin
            @(posedge aclk); #1;
            if (arvalid !== 1'b1 || araddr !== o_addr || arid !== o_id) o_bad++;
        end
        arready = 1;
        @(posedge aclk); #1;
        arready = 0;
        for (int b = 0; b < nbeats; b++) begin
            exp = 32'hA000_0000 + b; rl = (b == nbeats - 1);
            rvalid = 1; rdata = exp; rlast = rl; rid = rid_v;
            rresp = (b == bad_beat) ? 2'b10 : 2'b00;
            if (b >= bp_lo && b <= bp_hi) begin
                i_rready = own_d; d_rready = !own_d;
                #1;
                if (rready !== 1'b0) o_bad++;
                @(posedge aclk); #1;
            end
            i_rready = 1; d_rready = 1;
            #1;
            if (rready !== 1'b1) o_bad++;
            if (own_d) begin
                if (d_rvalid !== 1'b1 || d_rdata !== exp || d_rlast !== rl || i_rvalid !== 1'b0) o_bad++;
            end else begin
                if (i_rvalid !== 1'b1 || i_rdata !== exp || i_rlast !== rl || d_rvalid !== 1'b0) o_bad++;
            end
            o_got++;
            @(posedge aclk); #1;
        end
        rvalid = 0; rlast = 0; rresp = 0;
    endtask

    task automatic test_reset();
        i_arvalid = 1; d_arvalid = 1; rvalid = 1;
        #3;
        n_chk++;
        if ({arvalid, i_arready, d_arready, rready, i_rvalid, d_rvalid, rd_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000000",
                {arvalid, i_arready, d_arready, rready, i_rvalid, d_rvalid, rd_err});
        end
        n_chk++;
        if ({arid, araddr, arlen, arsize} !== 47'h0 || arburst !== 2'b01 ||
            {arlock, arcache, arprot} !== 9'h0) begin
            n_fail++; $display("FAIL reset_payload: got %h %h %h %h burst %b", arid, araddr, arlen, arsize, arburst);
        end
        i_arvalid = 0; d_arvalid = 0; rvalid = 0;
        do_reset();
    endtask

    task automatic test_single_icache();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        @(posedge aclk); #1;
        i_arvalid = 1; i_araddr = 32'h1FC0_0000; i_arlen = 8'd7; i_arsize = 3'd2;
        #1;
        n_chk++;
        if (i_arready !== 1'b1 || d_arready !== 1'b0) begin
            n_fail++; $display("FAIL single_grant: i_arready %b d_arready %b want 1 0", i_arready, d_arready);
        end
        @(posedge aclk); #1;
        n_chk++;
        if (i_arready !== 1'b0 || arvalid !== 1'b1) begin
            n_fail++; $display("FAIL single_pulse: i_arready %b arvalid %b want 0 1", i_arready, arvalid);
        end
        i_arvalid = 0; i_araddr = 32'hDEAD_BEEF;
        serve(2, 8, 4'd0, -1, 99, 99, id, ad, ln, got, bad);
        n_chk++;
        if (id !== 4'd0 || ad !== 32'h1FC0_0000 || ln !== 8'd7 || arsize !== 3'd2) begin
            n_fail++; $display("FAIL single_ar: got id %h addr %h len %h want 0 1fc00000 07", id, ad, ln);
        end
        n_chk++;
        if (got !== 8 || bad !== 0) begin
            n_fail++; $display("FAIL single_beats: got %0d beats %0d errors want 8 0", got, bad);
        end
        rvalid = 1; #1;
        n_chk++;
        if (rready !== 1'b0 || i_rvalid !== 1'b0 || arvalid !== 1'b0 || rd_err !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: rready %b i_rvalid %b arvalid %b rd_err %b want 0000",
                rready, i_rvalid, arvalid, rd_err);
        end
        rvalid = 0;
    endtask

    task automatic test_round_robin();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        do_reset();
        @(posedge aclk); #1;
        for (int r = 0; r < 2; r++) begin
            i_arvalid = 1; i_araddr = 32'h0000_1000 + r * 32'h100; i_arlen = 8'd2;
            d_arvalid = 1; d_araddr = 32'h8000_0000 + r * 32'h100; d_arlen = 8'd3;
            #1;
            n_chk++;
            if (d_arready !== 1'b1 || i_arready !== 1'b0) begin
                n_fail++; $display("FAIL rr_tie%0d: d_arready %b i_arready %b want 1 0", r, d_arready, i_arready);
            end
            @(posedge aclk); #1;
            d_arvalid = 0;
            serve(1, 4, 4'd1, -1, 99, 99, id, ad, ln, got, bad);
            n_chk++;
            if (id !== 4'd1 || ad !== 32'h8000_0000 + r * 32'h100 || got !== 4 || bad !== 0) begin
                n_fail++; $display("FAIL rr_d%0d: id %h addr %h beats %0d err %0d want 1 %h 4 0",
                    r, id, ad, got, bad, 32'h8000_0000 + r * 32'h100);
            end
            #1;
            n_chk++;
            if (i_arready !== 1'b1) begin
                n_fail++; $display("FAIL rr_bubble%0d: i_arready %b want 1", r, i_arready);
            end
            @(posedge aclk); #1;
            i_arvalid = 0;
            serve(0, 3, 4'd0, -1, 99, 99, id, ad, ln, got, bad);
            n_chk++;
            if (id !== 4'd0 || ad !== 32'h0000_1000 + r * 32'h100 || got !== 3 || bad !== 0) begin
                n_fail++; $display("FAIL rr_i%0d: id %h addr %h beats %0d err %0d want 0 %h 3 0",
                    r, id, ad, got, bad, 32'h0000_1000 + r * 32'h100);
            end
        end
        n_chk++;
        if (rd_err !== 1'b0) begin
            n_fail++; $display("FAIL rr_err: rd_err %b want 0", rd_err);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        d_arvalid = 1; d_araddr = 32'h8000_4000; d_arlen = 8'd3;
        @(posedge aclk); #1;
        d_arvalid = 0;
        serve(0, 4, 4'd1, -1, 1, 3, id, ad, ln, got, bad);
        n_chk++;
        if (id !== 4'd1 || got !== 4 || bad !== 0 || rd_err !== 1'b0) begin
            n_fail++; $display("FAIL backpressure: id %h beats %0d err %0d rd_err %b want 1 4 0 0", id, got, bad, rd_err);
        end
    endtask

    task automatic test_early_rlast();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        i_arvalid = 1; i_araddr = 32'h0000_2000; i_arlen = 8'd7;
        @(posedge aclk); #1;
        i_arvalid = 0;
        serve(0, 2, 4'd0, -1, 99, 99, id, ad, ln, got, bad);
        rvalid = 1; #1;
        n_chk++;
        if (got !== 2 || bad !== 0 || rready !== 1'b0 || rd_err !== 1'b1) begin
            n_fail++; $display("FAIL early_rlast: beats %0d err %0d rready %b rd_err %b want 2 0 0 1", got, bad, rready, rd_err);
        end
        rvalid = 0;
        d_arvalid = 1; d_araddr = 32'h8000_5000; d_arlen = 8'd1;
        @(posedge aclk); #1;
        d_arvalid = 0;
        serve(0, 2, 4'd1, -1, 99, 99, id, ad, ln, got, bad);
        n_chk++;
        if (got !== 2 || bad !== 0 || rd_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: beats %0d err %0d rd_err %b want 2 0 1", got, bad, rd_err);
        end
    endtask

    task automatic test_rresp_rid();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        do_reset();
        i_arvalid = 1; i_araddr = 32'h0000_3000; i_arlen = 8'd3;
        @(posedge aclk); #1;
        i_arvalid = 0;
        serve(0, 4, 4'd0, 2, 99, 99, id, ad, ln, got, bad);
        n_chk++;
        if (got !== 4 || bad !== 0 || rd_err !== 1'b1) begin
            n_fail++; $display("FAIL rresp_err: beats %0d err %0d rd_err %b want 4 0 1", got, bad, rd_err);
        end
        do_reset();
        i_arvalid = 1;
        @(posedge aclk); #1;
        i_arvalid = 0;
        serve(0, 4, 4'd1, -1, 99, 99, id, ad, ln, got, bad);
        n_chk++;
        if (got !== 4 || bad !== 0 || rd_err !== 1'b1) begin
            n_fail++; $display("FAIL rid_err: beats %0d err %0d rd_err %b want 4 0 1", got, bad, rd_err);
        end
    endtask

    task automatic test_late_rlast();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        do_reset();
        d_arvalid = 1; d_araddr = 32'h8000_6000; d_arlen = 8'd1;
        @(posedge aclk); #1;
        d_arvalid = 0;
        serve(0, 3, 4'd1, -1, 99, 99, id, ad, ln, got, bad);
        n_chk++;
        if (got !== 3 || bad !== 0 || rd_err !== 1'b1) begin
            n_fail++; $display("FAIL late_rlast: beats %0d err %0d rd_err %b want 3 0 1", got, bad, rd_err);
        end
    endtask

    task automatic test_oversize();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        do_reset();
        i_arvalid = 1; i_araddr = 32'h0000_7000; i_arlen = 8'd16;
        #1;
        n_chk++;
        if (rd_err !== 1'b0) begin
            n_fail++; $display("FAIL oversize_pre: rd_err %b want 0", rd_err);
        end
        @(posedge aclk); #1;
        i_arvalid = 0;
        n_chk++;
        if (rd_err !== 1'b1 || arlen !== 8'd16) begin
            n_fail++; $display("FAIL oversize_grant: rd_err %b arlen %h want 1 10", rd_err, arlen);
        end
        serve(0, 17, 4'd0, -1, 99, 99, id, ad, ln, got, bad);
        n_chk++;
        if (got !== 17 || bad !== 0) begin
            n_fail++; $display("FAIL oversize_beats: beats %0d err %0d want 17 0", got, bad);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] id; logic [31:0] ad; logic [7:0] ln; int got, bad;
        i_arvalid = 1; i_araddr = 32'h1FC0_0040; i_arlen = 8'd7;
        @(posedge aclk); #1;
        i_arvalid = 0;
        arready = 1;
        @(posedge aclk); #1;
        arready = 0;
        rvalid = 1; rid = 4'd0; rdata = 32'h1234_5678;
        repeat (3) @(posedge aclk);
        #3 aresetn = 0; i_arvalid = 1;
        #1;
        n_chk++;
        if ({arvalid, i_arready, d_arready, rready, i_rvalid, d_rvalid, rd_err} !== 7'b0 ||
            {arid, araddr, arlen} !== 44'h0) begin
            n_fail++; $display("FAIL async_reset: ctrl %b arid %h araddr %h arlen %h want 0",
                {arvalid, i_arready, d_arready, rready, i_rvalid, d_rvalid, rd_err}, arid, araddr, arlen);
        end
        rvalid = 0;
        @(posedge aclk); #1;
        aresetn = 1;
        i_araddr = 32'h1FC0_0080; i_arlen = 8'd7;
        #1;
        n_chk++;
        if (i_arready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_grant: i_arready %b want 1", i_arready);
        end
        @(posedge aclk); #1;
        i_arvalid = 0;
        serve(1, 8, 4'd0, -1, 99, 99, id, ad, ln, got, bad);
        n_chk++;
        if (id !== 4'd0 || ad !== 32'h1FC0_0080 || got !== 8 || bad !== 0 || rd_err !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_burst: id %h addr %h beats %0d err %0d rd_err %b want 0 1fc00080 8 0 0",
                id, ad, got, bad, rd_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_icache();
        test_round_robin();
        test_backpressure();
        test_early_rlast();
        test_rresp_rid();
        test_late_rlast();
        test_oversize();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
